alu_seq_unit: RTL and testbench

- Execution stage directly downstream of the 8x8 register file.
- Consumes the two register-file read ports (DATA1 = OUT1, DATA2 = OUT2) and produces RESULT for the register-file write port IN.
- Single-cycle ops: FWD/ADD/AND/OR. Multi-cycle iterative ops: MUL (shift-add) and SLL/SRL/SRA (one bit per cycle).
- BUSY drives the control unit's PC/regfile-write stall.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_comb.sv | 31 +++
 rtl/alu_seq_unit.sv | 168 ++++++++++++++++
 tb/tb_alu_seq_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, state and width definitions for the ALU slice
//
// Purpose: ALUOP encodings, FSM state type and default datapath width shared by
//          alu_comb and alu_seq_unit.
// Ports:   none (package).

package alu_pkg;

    localparam int ALU_WIDTH = 8;

    localparam logic [2:0] ALU_FWD = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_MUL = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SRL = 3'b110;
    localparam logic [2:0] ALU_SRA = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIN  = 2'b10
    } state_t;

endpackage

// File: rtl/alu_comb.sv
// rtl/alu_comb.sv - combinational FWD/ADD/AND/OR datapath
//
// Purpose: single-cycle ALU operations; any other opcode yields zero.
// Ports:   op_i  - operation select (ALU_* encoding)
//          a_i   - operand A
//          b_i   - operand B
//          y_o   - result

module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o
);

    always_comb begin
        y_o = '0;
        case (op_i)
            ALU_FWD: y_o = b_i;
            ALU_ADD: y_o = a_i + b_i;
            ALU_AND: y_o = a_i & b_i;
            ALU_OR:  y_o = a_i | b_i;
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq_unit.sv
// rtl/alu_seq_unit.sv - ALU execution stage with iterative multiply and shifts
//
// Purpose: single-cycle FWD/ADD/AND/OR, shift-add MUL over MUL_ITER cycles and
//          one-bit-per-cycle SLL/SRL/SRA, sequenced by an IDLE/RUN/FIN FSM.
// Ports:   CLK    - clock, all state on posedge
//          RESET  - asynchronous active-high reset
//          START  - request, sampled only in IDLE
//          ALUOP  - operation select, latched with START
//          DATA1  - operand A
//          DATA2  - operand B or unsigned shift amount
//          RESULT - registered result
//          ZERO   - registered (RESULT == 0)
//          BUSY   - high while a multi-cycle op iterates
//          DONE   - one-cycle pulse when RESULT is newly valid

module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int WIDTH    = ALU_WIDTH,
    parameter int MUL_ITER = ALU_WIDTH
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [2:0]       ALUOP,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    output logic [WIDTH-1:0] RESULT,
    output logic             ZERO,
    output logic             BUSY,
    output logic             DONE
);

    localparam int               CNT_W     = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] SHIFT_SAT = WIDTH'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MUL   = CNT_W'(MUL_ITER);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q;
    logic [2:0]       op_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_q;       // multiplicand, or shift register
    logic [WIDTH-1:0] b_q;       // multiplier
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] comb_y;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] iter_y;
    logic [CNT_W-1:0] shamt;

    alu_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .op_i (ALUOP),
        .a_i  (DATA1),
        .b_i  (DATA2),
        .y_o  (comb_y)
    );

    // Shift amounts at or above WIDTH saturate: all bits shifted out.
    always_comb begin
        shamt = (DATA2 >= SHIFT_SAT) ? CNT_FULL : DATA2[CNT_W-1:0];
    end

    // One iteration of the latched multi-cycle op.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        case (op_q)
            ALU_MUL: begin
                if (b_q[0]) begin
                    acc_d = acc_q + a_q;
                end
                a_d = a_q << 1;
                b_d = b_q >> 1;
            end
            ALU_SLL: a_d = {a_q[WIDTH-2:0], 1'b0};
            ALU_SRL: a_d = {1'b0, a_q[WIDTH-1:1]};
            ALU_SRA: a_d = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
            default: ;
        endcase
        iter_y = (op_q == ALU_MUL) ? acc_d : a_d;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            op_q     <= ALU_FWD;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (START) begin
                        op_q <= ALUOP;
                        a_q  <= DATA1;
                        b_q  <= DATA2;
                        if (ALUOP == ALU_MUL) begin
                            cnt_q   <= CNT_MUL;
                            acc_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= S_RUN;
                        end else if (ALUOP >= ALU_SLL) begin
                            if (shamt == '0) begin
                                result_q <= DATA1;
                                zero_q   <= (DATA1 == '0);
                                done_q   <= 1'b1;
                                state_q  <= S_FIN;
                            end else begin
                                cnt_q   <= shamt;
                                busy_q  <= 1'b1;
                                state_q <= S_RUN;
                            end
                        end else begin
                            result_q <= comb_y;
                            zero_q   <= (comb_y == '0);
                            done_q   <= 1'b1;
                            state_q  <= S_FIN;
                        end
                    end
                end
                S_RUN: begin
                    a_q   <= a_d;
                    b_q   <= b_d;
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        result_q <= iter_y;
                        zero_q   <= (iter_y == '0);
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_FIN;
                    end
                end
                S_FIN: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign RESULT = result_q;
    assign ZERO   = zero_q;
    assign BUSY   = busy_q;
    assign DONE   = done_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb/tb_alu_seq_unit.sv - directed self-checking bench for alu_seq_unit

module tb_alu_seq_unit;

    logic       CLK;
    logic       RESET;
    logic       START;
    logic [2:0] ALUOP;
    logic [7:0] DATA1;
    logic [7:0] DATA2;
    logic [7:0] RESULT;
    logic       ZERO;
    logic       BUSY;
    logic       DONE;

    int tests_run    = 0;
    int tests_failed = 0;

    alu_seq_unit #(
        .WIDTH    (8),
        .MUL_ITER (8)
    ) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .START  (START),
        .ALUOP  (ALUOP),
        .DATA1  (DATA1),
        .DATA2  (DATA2),
        .RESULT (RESULT),
        .ZERO   (ZERO),
        .BUSY   (BUSY),
        .DONE   (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one op, scramble the operand inputs after acceptance, then follow
    // BUSY/DONE until completion and check latency, result and pulse width.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] exp_y, input int exp_busy);
        int         cyc;
        int         busy_n;
        logic       held;
        logic [7:0] prev;
        prev = RESULT;
        held = 1'b1;
        @(negedge CLK);
        START = 1'b1;
        ALUOP = op;
        DATA1 = a;
        DATA2 = b;
        @(negedge CLK);
        START = 1'b0;
        DATA1 = 8'hA5;
        DATA2 = 8'h3C;
        cyc    = 0;
        busy_n = 0;
        while (!DONE && cyc < 20) begin
            if (BUSY) busy_n++;
            if (RESULT !== prev) held = 1'b0;
            @(negedge CLK);
            cyc++;
        end
        chk({tag, ".done"}, 32'(DONE), 32'd1);
        chk({tag, ".lat"}, 32'(cyc), 32'(exp_busy));
        chk({tag, ".busy"}, 32'(busy_n), 32'(exp_busy));
        chk({tag, ".busy_at_done"}, 32'(BUSY), 32'd0);
        chk({tag, ".held"}, 32'(held), 32'd1);
        chk({tag, ".y"}, 32'(RESULT), 32'(exp_y));
        chk({tag, ".z"}, 32'(ZERO), 32'(exp_y == 8'h00));
        @(negedge CLK);
        chk({tag, ".pulse"}, 32'(DONE), 32'd0);
    endtask

    initial begin
        int         dones;
        int         done_cyc;
        logic [7:0] y_at_done;

        RESET = 1'b1;
        START = 1'b0;
        ALUOP = 3'b000;
        DATA1 = 8'h00;
        DATA2 = 8'h00;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst.result", 32'(RESULT), 32'h00);
        chk("rst.zero", 32'(ZERO), 32'd1);
        chk("rst.busy", 32'(BUSY), 32'd0);
        chk("rst.done", 32'(DONE), 32'd0);

        run_op("add", 3'b001, 8'h05, 8'hFD, 8'h02, 0);
        run_op("mul", 3'b100, 8'h07, 8'hFD, 8'hEB, 8);
        run_op("sra2", 3'b111, 8'h90, 8'h02, 8'hE4, 2);
        run_op("sll9", 3'b101, 8'hFF, 8'h09, 8'h00, 8);
        run_op("fwd", 3'b000, 8'h11, 8'h80, 8'h80, 0);
        run_op("and", 3'b010, 8'hF0, 8'h3C, 8'h30, 0);
        run_op("or", 3'b011, 8'hF0, 8'h0C, 8'hFC, 0);
        run_op("srl3", 3'b110, 8'h90, 8'h03, 8'h12, 3);
        run_op("sra_sat", 3'b111, 8'h90, 8'hFF, 8'hFF, 8);
        run_op("srl8", 3'b110, 8'h7F, 8'h08, 8'h00, 8);
        run_op("sll0", 3'b101, 8'h5A, 8'h00, 8'h5A, 0);
        run_op("sll1", 3'b101, 8'h81, 8'h01, 8'h02, 1);
        run_op("mul_wrap", 3'b100, 8'h10, 8'h10, 8'h00, 8);
        run_op("mul_neg", 3'b100, 8'hFF, 8'hFF, 8'h01, 8);
        run_op("add_wrap", 3'b001, 8'h80, 8'h80, 8'h00, 0);

        // START held through FIN is ignored there and accepted on the IDLE edge.
        @(negedge CLK);
        START = 1'b1;
        ALUOP = 3'b001;
        DATA1 = 8'h01;
        DATA2 = 8'h02;
        @(negedge CLK);
        chk("b2b.first_done", 32'(DONE), 32'd1);
        chk("b2b.first_y", 32'(RESULT), 32'h03);
        ALUOP = 3'b011;
        DATA1 = 8'h0F;
        DATA2 = 8'hF0;
        @(negedge CLK);
        chk("b2b.fin_ignored", 32'(DONE), 32'd0);
        chk("b2b.fin_hold", 32'(RESULT), 32'h03);
        @(negedge CLK);
        START = 1'b0;
        chk("b2b.second_done", 32'(DONE), 32'd1);
        chk("b2b.second_y", 32'(RESULT), 32'hFF);
        @(negedge CLK);

        // START with ADD while MUL 3x4 is iterating must be dropped.
        @(negedge CLK);
        START = 1'b1;
        ALUOP = 3'b100;
        DATA1 = 8'h03;
        DATA2 = 8'h04;
        @(negedge CLK);
        START     = 1'b0;
        dones     = 0;
        done_cyc  = -1;
        y_at_done = 8'h00;
        for (int c = 0; c < 14; c++) begin
            if (DONE) begin
                if (dones == 0) begin
                    done_cyc  = c;
                    y_at_done = RESULT;
                end
                dones++;
            end
            if (c == 2) begin
                START = 1'b1;
                ALUOP = 3'b001;
                DATA1 = 8'h01;
                DATA2 = 8'h01;
            end else if (c == 3) begin
                START = 1'b0;
            end
            @(negedge CLK);
        end
        chk("run_start.dones", 32'(dones), 32'd1);
        chk("run_start.lat", 32'(done_cyc), 32'd8);
        chk("run_start.y", 32'(y_at_done), 32'h0C);

        // Asynchronous reset between edges in the middle of a MUL.
        START = 1'b1;
        ALUOP = 3'b100;
        DATA1 = 8'h03;
        DATA2 = 8'h05;
        @(negedge CLK);
        START = 1'b0;
        repeat (4) @(negedge CLK);
        chk("areset.busy_before", 32'(BUSY), 32'd1);
        #2;
        RESET = 1'b1;
        #1;
        chk("areset.busy", 32'(BUSY), 32'd0);
        chk("areset.result", 32'(RESULT), 32'h00);
        chk("areset.zero", 32'(ZERO), 32'd1);
        chk("areset.done", 32'(DONE), 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            if (DONE || BUSY) dones++;
            @(negedge CLK);
        end
        chk("areset.no_done", 32'(dones), 32'd0);
        run_op("post_reset_add", 3'b001, 8'h01, 8'h01, 8'h02, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
